// File: rtl/any1_pkg.sv
// any1_pkg: shared types and constants for the any1 core.
// Holds the ROB id width, the functional-unit id enumeration and the
// state encoding used by the dispatch per-FU sequencers.
package any1_pkg;

  // log2 of the ROB entry count
  localparam int RIDW = 6;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_FPU  = 2'd2,
    FU_MEM  = 2'd3
  } fu_id_e;

  typedef enum logic [1:0] {
    FD_IDLE = 2'd0,
    FD_EXEC = 2'd1,
    FD_WAIT = 2'd2
  } fd_state_e;

endpackage

// File: rtl/any1_rr_arbiter.sv
// any1_rr_arbiter: combinational round-robin arbiter for a shared port.
// Searches the request vector starting one position after ptr and wrapping,
// returning the first requester found.
// Ports:
//   req  - request vector, one bit per requester
//   en   - arbitration enable; no grant when low
//   ptr  - index of the most recently granted requester
//   gnt  - one-hot grant (all zero when nothing is granted)
//   idx  - encoded index of the granted requester (0 when none)
module any1_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Walk ptr+1 .. ptr+N (mod N); the first hit wins, later hits are ignored.
  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (en && !found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = IW'(k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/any1_fu_dispatch.sv
// any1_fu_dispatch: issues scheduler selections to functional units, tracks
// each unit's execution countdown and shares one writeback bus among the
// finished units through a round-robin arbiter.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   sel_v/rid/fu/lat   - scheduler selection (valid, ROB id, target FU, latency)
//   sel_ack            - combinational: selection accepted this cycle
//   flush              - branch-miss flush, discards all in-flight work
//   issue_v/issue_rid  - registered pulse telling the ROB an id went out
//   fu_start           - registered one-cycle start pulse per FU
//   fu_rid             - ROB id held by each FU (slice k belongs to FU k)
//   fu_busy            - FU not idle
//   wb_stall           - writeback port cannot accept this cycle
//   wb_v/wb_rid/wb_fu  - registered writeback pulse, id and producing FU
module any1_fu_dispatch
  import any1_pkg::*;
#(
  parameter int NFU  = 4,
  parameter int LATW = 6,
  parameter int RIDW = any1_pkg::RIDW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sel_v,
  input  logic [RIDW-1:0]     sel_rid,
  input  logic [1:0]          sel_fu,
  input  logic [LATW-1:0]     sel_lat,
  output logic                sel_ack,
  input  logic                flush,
  output logic                issue_v,
  output logic [RIDW-1:0]     issue_rid,
  output logic [NFU-1:0]      fu_start,
  output logic [NFU*RIDW-1:0] fu_rid,
  output logic [NFU-1:0]      fu_busy,
  input  logic                wb_stall,
  output logic                wb_v,
  output logic [RIDW-1:0]     wb_rid,
  output logic [1:0]          wb_fu
);

  localparam int PW = (NFU > 1) ? $clog2(NFU) : 1;

  fd_state_e       state [NFU];
  logic [LATW-1:0] cnt   [NFU];
  logic [RIDW-1:0] rid   [NFU];
  logic [NFU-1:0]  req;
  logic [NFU-1:0]  gnt;
  logic [NFU-1:0]  start;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic [LATW-1:0] lat_m1;
  logic            fu_ok;

  // A zero latency behaves like one, so the countdown preload never wraps.
  always_comb begin
    fu_ok   = int'(sel_fu) < NFU;
    sel_ack = sel_v && !flush && fu_ok && (state[sel_fu] == FD_IDLE);
    lat_m1  = (sel_lat == '0) ? '0 : sel_lat - LATW'(1);
  end

  // Flush blocks grants so no result leaks onto the bus during a branch miss.
  any1_rr_arbiter #(.N(NFU), .IW(PW)) u_wb_arb (
    .req (req),
    .en  (!wb_stall && !flush),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  for (genvar k = 0; k < NFU; k++) begin : g_fu
    assign req[k]                  = (state[k] == FD_WAIT);
    assign fu_busy[k]              = (state[k] != FD_IDLE);
    assign fu_rid[k*RIDW +: RIDW]  = rid[k];

    // Per-FU sequencer: IDLE -> EXEC (count down) -> WAIT (hold for bus).
    // Flush returns every unit to IDLE regardless of where it was.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state[k] <= FD_IDLE;
        cnt[k]   <= '0;
        rid[k]   <= '0;
        start[k] <= 1'b0;
      end else begin
        start[k] <= 1'b0;
        if (flush) begin
          state[k] <= FD_IDLE;
          cnt[k]   <= '0;
        end else begin
          case (state[k])
            FD_IDLE: begin
              if (sel_ack && (sel_fu == 2'(k))) begin
                state[k] <= FD_EXEC;
                cnt[k]   <= lat_m1;
                rid[k]   <= sel_rid;
                start[k] <= 1'b1;
              end
            end
            FD_EXEC: begin
              if (cnt[k] == '0) state[k] <= FD_WAIT;
              else              cnt[k]   <= cnt[k] - LATW'(1);
            end
            FD_WAIT: begin
              if (gnt[k]) state[k] <= FD_IDLE;
            end
            default: state[k] <= FD_IDLE;
          endcase
        end
      end
    end
  end

  assign fu_start = start;

  // Issue and writeback pulses are registered one cycle after accept/grant.
  // The pointer only moves on a real grant, so a flush leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_v   <= 1'b0;
      issue_rid <= '0;
      wb_v      <= 1'b0;
      wb_rid    <= '0;
      wb_fu     <= '0;
      ptr       <= PW'(NFU - 1);
    end else begin
      issue_v <= sel_ack;
      if (sel_ack) issue_rid <= sel_rid;
      wb_v <= |gnt;
      if (|gnt) begin
        wb_rid <= rid[gnt_idx];
        wb_fu  <= 2'(gnt_idx);
        ptr    <= gnt_idx;
      end
    end
  end

endmodule
